// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Responder end of the core's load/store port. It accepts one request at a
//   time, waits WAIT_CYCLES cycles, and then performs the byte, half or word
//   access on the commit edge. The result is held on the response port until
//   the core consumes it.
//
// Parameters
//   ADDR_W       word-address bits; the array holds 2**ADDR_W 32-bit words
//   WAIT_CYCLES  extra cycles between accept and response (0..15)
//
// Optional feature (macro MISALIGN_TRAP_EN)
//   When defined, a misaligned half or word access does not write. It returns
//   rdata=0 and resp_err=1. When undefined, the low address bits below the
//   access size are ignored and resp_err is tied to 0.
//
// Ports
//   clk, rst                  clock (rising edge) and synchronous active-high reset
//   req_valid / req_ready     request handshake (req_ready is registered)
//   req_write                 1 = store, 0 = load
//   req_addr                  byte address; only bits [ADDR_W+1:0] are used (wraps)
//   req_funct3                RV32I load/store funct3
//   req_wdata                 store data, right-aligned
//   resp_valid / resp_ready   response handshake
//   resp_rdata                extended load data; 0 for stores
//   resp_err                  misaligned access (feature-dependent)
module data_mem_responder #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = ADDR_W + 2;  // byte-address bits actually decoded
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        req_ready_q, req_ready_d;
    logic        write_q, write_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;

    logic [31:0] mem [2**ADDR_W];

    // Upper address bits do not take part in decoding; the array wraps.
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:AW];

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            req_ready_q <= 1'b1;
            write_q     <= 1'b0;
            addr_q      <= '0;
            funct3_q    <= 3'd0;
            wdata_q     <= 32'd0;
            rdata_q     <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            funct3_q    <= funct3_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    logic accept;
    assign accept = (state_q == S_IDLE) && req_valid;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (req_valid)     state_d = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
            S_WAIT: if (cnt_q == 4'd0) state_d = S_RESP;
            S_RESP: if (resp_ready)    state_d = S_IDLE;
            default:                   state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. req_ready is precomputed from the next state so that it
    // comes from a flop and is already low in RESP.
    // ------------------------------------------------------------------
    always_comb begin
        req_ready_d = (state_d == S_IDLE);
        req_ready   = req_ready_q;
        resp_valid  = (state_q == S_RESP);
        resp_rdata  = rdata_q;
    end

    // ------------------------------------------------------------------
    // Access datapath
    // ------------------------------------------------------------------
    // With WAIT_CYCLES=0 the commit happens on the accept edge. In that case
    // the access is taken from the live request instead of the latches.
    logic          commit;
    logic          acc_write;
    logic [AW-1:0] acc_addr;
    logic [2:0]    acc_f3;
    logic [31:0]   acc_wdata;

    always_comb begin
        commit    = ((state_q == S_WAIT) && (cnt_q == 4'd0)) ||
                    (accept && (WAIT_CYCLES == 0));
        acc_write = accept ? req_write           : write_q;
        acc_addr  = accept ? req_addr[AW-1:0]    : addr_q;
        acc_f3    = accept ? req_funct3          : funct3_q;
        acc_wdata = accept ? req_wdata           : wdata_q;

        write_d  = accept ? req_write        : write_q;
        addr_d   = accept ? req_addr[AW-1:0] : addr_q;
        funct3_d = accept ? req_funct3       : funct3_q;
        wdata_d  = accept ? req_wdata        : wdata_q;

        cnt_d = cnt_q;
        if (accept)
            cnt_d = CNT_INIT;
        else if ((state_q == S_WAIT) && (cnt_q != 4'd0))
            cnt_d = cnt_q - 4'd1;
    end

    logic [ADDR_W-1:0] mem_idx;
    logic [31:0]       rword;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic [31:0]       load_val;
    logic [3:0]        wr_be;
    logic [31:0]       wr_data;
    logic              misalign;
    logic              wr_en;

    assign mem_idx = acc_addr[AW-1:2];
    assign rword   = mem[mem_idx];

    always_comb begin
        rd_byte = rword[{acc_addr[1:0], 3'b000} +: 8];
        rd_half = acc_addr[1] ? rword[31:16] : rword[15:0];
        case (acc_f3)
            3'b000:  load_val = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  load_val = {{16{rd_half[15]}}, rd_half};
            3'b100:  load_val = {24'd0, rd_byte};
            3'b101:  load_val = {16'd0, rd_half};
            default: load_val = rword;
        endcase

        // Byte and half stores replicate the data across lanes; the enables pick the lane.
        case (acc_f3)
            3'b000: begin
                wr_be   = 4'b0001 << acc_addr[1:0];
                wr_data = {4{acc_wdata[7:0]}};
            end
            3'b001: begin
                wr_be   = acc_addr[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{acc_wdata[15:0]}};
            end
            default: begin
                wr_be   = 4'b1111;
                wr_data = acc_wdata;
            end
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    logic is_half, is_byte;
    logic err_q, err_d;

    always_comb begin
        // Stores only know SB/SH; every other funct3 is a word store.
        // Loads also have LBU/LHU.
        is_byte  = acc_write ? (acc_f3 == 3'b000) : (acc_f3[1:0] == 2'b00);
        is_half  = acc_write ? (acc_f3 == 3'b001) : (acc_f3[1:0] == 2'b01);
        misalign = is_half ? acc_addr[0] :
                   is_byte ? 1'b0        : (acc_addr[1:0] != 2'b00);
        err_d    = commit ? misalign : err_q;
    end

    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign resp_err = err_q;
`else
    assign misalign = 1'b0;
    assign resp_err = 1'b0;
`endif

    always_comb begin
        rdata_d = rdata_q;
        if (commit)
            rdata_d = (acc_write || misalign) ? 32'd0 : load_val;
    end

    // A reset on the commit edge abandons the access.
    assign wr_en = commit && acc_write && !misalign && !rst;

    // Memory is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++)
                if (wr_be[b]) mem[mem_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
    end

endmodule
